text_overlay: RTL
=================

TEXT_OVERLAY -- requirements
Module: text_overlay

Interface
REQ-001 Parameter MAX_CHARS, default 8, SHALL set the number of character cells in one text string (1..16).
REQ-002 Parameter PIX_W, default 6, SHALL set the palette-index width of the pixel output.
REQ-003 Parameter BLINK_FRAMES, default 30, SHALL set the frames per blink half-period (used only under TEXT_BLINK_EN).
REQ-004 Clk  in  1  sole clock; all state SHALL change on its rising edge only.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 frame_start  in  1  one-cycle pulse at the first pixel of each frame.
REQ-007 DrawX, DrawY  in  10 each  current pixel coordinates.
REQ-008 org_x, org_y  in  10 each  top-left pixel of the string box.
REQ-009 scale_log2  in  2  glyph magnification 1x/2x/4x; value 3 SHALL be treated as 2.
REQ-010 fg_color  in  PIX_W  palette index for lit glyph pixels.
REQ-011 wr_en, wr_addr[3:0], wr_code[3:0]  in  write one character code into cell wr_addr.
REQ-012 text_on  out  1  current pixel is a lit glyph pixel.
REQ-013 text_pix  out  PIX_W  fg_color when text_on, else 0.

Function
REQ-014 Glyph codes SHALL be: 0 blank, 1 S, 2 C, 3 O, 4 R, 5 E, 6 T, 7 I, 8 M; codes 9..15 SHALL render blank.
REQ-015 Each glyph SHALL be a 14x14 1-bit bitmap, placed in a 16x14 cell (two blank columns on the right).
REQ-016 Stage 1 SHALL compute rx = DrawX-org_x and ry = DrawY-org_y as 10-bit unsigned values, then u = rx>>s and v = ry>>s, where s = the effective scale.
REQ-017 In-box SHALL hold iff DrawX>=org_x, DrawY>=org_y, v<14 and (u>>4)<MAX_CHARS; cell = u>>4, col = u[3:0], row = v.
REQ-018 col 14 or 15 SHALL render unlit.
REQ-019 Stage 2 SHALL look up display[cell] and the glyph bit at (row, col), then register text_on and text_pix.
REQ-020 Latency SHALL be exactly 2 Clk cycles from DrawX/DrawY to text_on/text_pix; the pipeline SHALL not stall.
REQ-021 The write buffer SHALL be a shadow array: wr_en with wr_addr<MAX_CHARS updates shadow[wr_addr]; wr_addr>=MAX_CHARS SHALL be ignored.
REQ-022 On frame_start the display array SHALL load the whole shadow array, so text never tears mid-frame.
REQ-023 wr_en coincident with frame_start SHALL be included in that cycle's copy.
REQ-024 Multiple writes to one cell within a frame: the last write SHALL win.
REQ-025 org, scale and fg_color changes SHALL take effect with the same 2-cycle latency; they are not frame-synchronised.

Reset
REQ-026 Reset SHALL clear shadow, display, both pipeline stages, text_on, text_pix and the blink state to 0.
REQ-027 Reset asserted mid-frame SHALL override all writes and frame_start in the same cycle.
REQ-028 Outputs SHALL stay 0 for 2 cycles after Reset deasserts.

Configuration
REQ-029 Macro TEXT_BLINK_EN, when defined, SHALL add the input port blink (1 bit) and a frame counter counting frame_start pulses.
REQ-030 Under TEXT_BLINK_EN, the blink phase SHALL toggle every BLINK_FRAMES frames.
REQ-031 Under TEXT_BLINK_EN, blink=1 with phase=1 SHALL force text_on=0 and text_pix=0.
REQ-032 Under TEXT_BLINK_EN, blink=0 SHALL hold the counter and phase at 0.
REQ-033 Without TEXT_BLINK_EN, neither the blink port nor the counter SHALL exist, and text is never blanked.

Structure
REQ-034 Package text_pkg SHALL hold GLYPH_W=14, GLYPH_H=14, CELL_W=16, CODE_W=4 and the glyph-code enum.
REQ-035 Sub-module glyph_rom SHALL be a combinational map of (code, row, col) to one lit bit, instantiated once in stage 2.

Verification
REQ-036 Reset; write S,C,O,R,E to cells 0-4; pulse frame_start; org=(100,50), scale 0 -> pixel (100,50) is unlit (S row 0, col 0); pixel (102,50) gives text_on=1, text_pix=fg 5 exactly 2 cycles later.
REQ-037 scale_log2=1, org=(0,0), cell 0=T -> DrawX 0..27, DrawY 0..3 lit; DrawX 28..31 unlit (gap columns); DrawY 28 unlit.
REQ-038 Write cell 2=M mid-frame without frame_start -> old glyph persists for the rest of the frame; new glyph appears after the next frame_start.
REQ-039 wr_en with frame_start in the same cycle, cell 0=O -> O visible in that frame; wr_addr=9 with MAX_CHARS=8 -> no change.
REQ-040 Assert Reset mid-scan with text lit -> text_on=0 the next cycle; all cells blank after the next frame_start.
REQ-041 With TEXT_BLINK_EN, BLINK_FRAMES=2, blink=1 -> text visible in frames 0-1, blanked in frames 2-3, visible in frames 4-5.

Source files
------------

// File: rtl/text_pkg.sv
// Shared constants, glyph codes and helpers for the text overlay.
package text_pkg;

    localparam int GLYPH_W = 14;
    localparam int GLYPH_H = 14;
    localparam int CELL_W  = 16;
    localparam int CODE_W  = 4;

    typedef enum logic [CODE_W-1:0] {
        G_BLANK = 4'd0,
        G_S     = 4'd1,
        G_C     = 4'd2,
        G_O     = 4'd3,
        G_R     = 4'd4,
        G_E     = 4'd5,
        G_T     = 4'd6,
        G_I     = 4'd7,
        G_M     = 4'd8
    } glyph_code_e;

    // Magnification 8x is not supported; the top encoding falls back to 4x.
    function automatic logic [1:0] eff_scale(input logic [1:0] s);
        return (s == 2'd3) ? 2'd2 : s;
    endfunction

endpackage

// File: rtl/text_overlay_glyph_rom.sv
// Combinational glyph ROM: (code, row, col) -> lit bit for the 14x14 font.
module glyph_rom
    import text_pkg::*;
(
    input  logic [CODE_W-1:0] i_code,
    input  logic [3:0]        i_row,
    input  logic [3:0]        i_col,
    output logic              o_lit
);

    // Row words are 16 bits wide: col 0 is the MSB, the two LSBs are the cell gap.
    // Rows 14 and 15 are padding so any 4-bit row index is safe.
    typedef logic [0:15][15:0] bitmap_t;

    localparam bitmap_t S_BM = {{2{16'b0011111111111100}}, {4{16'b1100000000000000}},
                                {2{16'b0011111111110000}}, {4{16'b0000000000001100}},
                                {2{16'b1111111111110000}}, {2{16'h0000}}};
    localparam bitmap_t C_BM = {{2{16'b0011111111111100}}, {10{16'b1100000000000000}},
                                {2{16'b0011111111111100}}, {2{16'h0000}}};
    localparam bitmap_t O_BM = {{2{16'b0011111111110000}}, {10{16'b1100000000001100}},
                                {2{16'b0011111111110000}}, {2{16'h0000}}};
    localparam bitmap_t R_BM = {{2{16'b1111111111110000}}, {4{16'b1100000000001100}},
                                {2{16'b1111111111110000}}, {6{16'b1100000000001100}},
                                {2{16'h0000}}};
    localparam bitmap_t E_BM = {{2{16'b1111111111111100}}, {4{16'b1100000000000000}},
                                {2{16'b1111111111111100}}, {4{16'b1100000000000000}},
                                {2{16'b1111111111111100}}, {2{16'h0000}}};
    localparam bitmap_t T_BM = {{2{16'b1111111111111100}}, {12{16'b0000001100000000}},
                                {2{16'h0000}}};
    localparam bitmap_t I_BM = {{2{16'b1111111111111100}}, {10{16'b0000001100000000}},
                                {2{16'b1111111111111100}}, {2{16'h0000}}};
    localparam bitmap_t M_BM = {{2{16'b1100000000001100}}, {2{16'b1100110011001100}},
                                {2{16'b1100111111001100}}, {2{16'b1100001100001100}},
                                {6{16'b1100000000001100}}, {2{16'h0000}}};

    logic [15:0] w_row;

    always_comb begin
        w_row = '0;
        case (i_code)
            G_S:     w_row = S_BM[i_row];
            G_C:     w_row = C_BM[i_row];
            G_O:     w_row = O_BM[i_row];
            G_R:     w_row = R_BM[i_row];
            G_E:     w_row = E_BM[i_row];
            G_T:     w_row = T_BM[i_row];
            G_I:     w_row = I_BM[i_row];
            G_M:     w_row = M_BM[i_row];
            default: w_row = '0;
        endcase
    end

    assign o_lit = (i_col < 4'(GLYPH_W)) && w_row[4'd15 - i_col];

endmodule

// File: rtl/text_overlay.sv
// Two-stage text overlay: string box hit test, then glyph lookup from a frame-latched buffer.
// Optional macro TEXT_BLINK_EN adds a blink input and a frame-counted blink phase.
module text_overlay
    import text_pkg::*;
#(
    parameter int MAX_CHARS    = 8,
    parameter int PIX_W        = 6,
    parameter int BLINK_FRAMES = 30
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_start,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        org_x,
    input  logic [9:0]        org_y,
    input  logic [1:0]        scale_log2,
    input  logic [PIX_W-1:0]  fg_color,
    input  logic              wr_en,
    input  logic [3:0]        wr_addr,
    input  logic [CODE_W-1:0] wr_code,
`ifdef TEXT_BLINK_EN
    input  logic              blink,
`endif
    output logic              text_on,
    output logic [PIX_W-1:0]  text_pix
);

    localparam logic [5:0] MAX_CELLS = 6'(MAX_CHARS);

    logic [1:0]        w_s;
    logic [9:0]        w_rx, w_ry, w_u, w_v;
    logic              w_inbox;
    logic              w_wr_ok;
    logic [CODE_W-1:0] w_code;
    logic              w_lit;
    logic              w_on;
    logic              w_blank;

    // Sized to 16 so any 4-bit cell index is in range; cells >= MAX_CHARS stay blank.
    logic [CODE_W-1:0] r_shadow  [16];
    logic [CODE_W-1:0] r_display [16];

    logic              r_inbox_p1;
    logic [3:0]        r_cell_p1, r_col_p1, r_row_p1;
    logic [PIX_W-1:0]  r_fg_p1;
    logic              r_text_on;
    logic [PIX_W-1:0]  r_text_pix;

    assign w_wr_ok = wr_en && ({2'b00, wr_addr} < MAX_CELLS);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 16; i++) begin
                r_shadow[i]  <= '0;
                r_display[i] <= '0;
            end
        end else begin
            if (w_wr_ok) begin
                r_shadow[wr_addr] <= wr_code;
            end
            // A write landing on the frame_start cycle goes straight into the copy.
            if (frame_start) begin
                for (int i = 0; i < 16; i++) begin
                    r_display[i] <= (w_wr_ok && wr_addr == 4'(i)) ? wr_code : r_shadow[i];
                end
            end
        end
    end

    // Stage 1: box-relative coordinates and hit test
    assign w_s  = eff_scale(scale_log2);
    assign w_rx = DrawX - org_x;
    assign w_ry = DrawY - org_y;
    assign w_u  = w_rx >> w_s;
    assign w_v  = w_ry >> w_s;

    assign w_inbox = (DrawX >= org_x) && (DrawY >= org_y) &&
                     (w_v < 10'(GLYPH_H)) && (w_u[9:4] < MAX_CELLS);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_inbox_p1 <= 1'b0;
            r_cell_p1  <= '0;
            r_col_p1   <= '0;
            r_row_p1   <= '0;
            r_fg_p1    <= '0;
        end else begin
            r_inbox_p1 <= w_inbox;
            r_cell_p1  <= w_u[7:4];
            r_col_p1   <= w_u[3:0];
            r_row_p1   <= w_v[3:0];
            r_fg_p1    <= fg_color;
        end
    end

    // Stage 2: glyph lookup and output register
    assign w_code = r_display[r_cell_p1];

    glyph_rom u_glyph_rom (
        .i_code (w_code),
        .i_row  (r_row_p1),
        .i_col  (r_col_p1),
        .o_lit  (w_lit)
    );

    assign w_on = r_inbox_p1 && w_lit && (r_col_p1 < 4'(GLYPH_W)) && !w_blank;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_text_on  <= 1'b0;
            r_text_pix <= '0;
        end else begin
            r_text_on  <= w_on;
            r_text_pix <= w_on ? r_fg_p1 : '0;
        end
    end

    assign text_on  = r_text_on;
    assign text_pix = r_text_pix;

`ifdef TEXT_BLINK_EN
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CNT_W-1:0] r_frame_cnt;
    logic             r_phase;
    logic             r_seen;
    logic             r_blink_p1;

    // The first frame_start opens frame 0 without advancing the count.
    always_ff @(posedge Clk) begin
        if (Reset || !blink) begin
            r_frame_cnt <= '0;
            r_phase     <= 1'b0;
            r_seen      <= 1'b0;
        end else if (frame_start) begin
            if (!r_seen) begin
                r_seen <= 1'b1;
            end else if (r_frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                r_frame_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_blink_p1 <= 1'b0;
        end else begin
            r_blink_p1 <= blink;
        end
    end

    assign w_blank = r_blink_p1 && r_phase;
`else
    assign w_blank = 1'b0;
`endif

endmodule
